// File: rtl/m2_block_scheduler.sv
// Purpose: frame-level sequencer for the milestone-2 IDCT; pipelines FS/CT/CS/WS over all blocks and owns the SRAM port.
// Latency: start pulses one cycle after M2_start or after the last required done of a phase; one cycle overhead per phase.
// Backpressure: each phase waits for a fresh rising done from every unit it started; M2_start is ignored while busy.
module m2_block_scheduler #(
  parameter int unsigned NUM_BLOCKS = 2400
) (
  input  logic        CLOCK_50_I,
  input  logic        Resetn,
  input  logic        M2_start,
  output logic        M2_done,
  output logic        FS_start,
  output logic        CT_start,
  output logic        CS_start,
  output logic        WS_start,
  input  logic        FS_done,
  input  logic        CT_done,
  input  logic        CS_done,
  input  logic        WS_done,
  input  logic [17:0] FS_SRAM_address,
  input  logic [17:0] WS_SRAM_address,
  input  logic [15:0] WS_SRAM_write_data,
  input  logic        WS_SRAM_we_n,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic [11:0] fetch_count,
  output logic [11:0] write_count
);

  // Block count in counter width; legal NUM_BLOCKS always fits in 12 bits.
  localparam logic [11:0] BLOCKS_TOTAL = 12'(NUM_BLOCKS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LI_FS,
    S_LI_CT,
    S_CC_A,
    S_CC_B,
    S_LO_CS,
    S_LO_WS,
    S_DONE
  } state_t;

  state_t state;

  // Previous-cycle done levels, used to find rising edges.
  logic fs_done_q, ct_done_q, cs_done_q, ws_done_q;
  // Sticky "finished since my last start" flags.
  logic fs_flag, ct_flag, cs_flag, ws_flag;

  logic fs_rise, ct_rise, cs_rise, ws_rise;
  logic fs_ok, ct_ok, cs_ok, ws_ok;

  // Only a fresh 0->1 transition counts; a level left high from an older run does not.
  assign fs_rise = FS_done & ~fs_done_q;
  assign ct_rise = CT_done & ~ct_done_q;
  assign cs_rise = CS_done & ~cs_done_q;
  assign ws_rise = WS_done & ~ws_done_q;

  // A rising edge seen this cycle completes the unit without waiting for its flag to register.
  assign fs_ok = fs_flag | fs_rise;
  assign ct_ok = ct_flag | ct_rise;
  assign cs_ok = cs_flag | cs_rise;
  assign ws_ok = ws_flag | ws_rise;

  // Sequencer: state, registered start pulses, sticky done flags and block counters.
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      state       <= S_IDLE;
      M2_done     <= 1'b0;
      FS_start    <= 1'b0;
      CT_start    <= 1'b0;
      CS_start    <= 1'b0;
      WS_start    <= 1'b0;
      fs_done_q   <= 1'b0;
      ct_done_q   <= 1'b0;
      cs_done_q   <= 1'b0;
      ws_done_q   <= 1'b0;
      fs_flag     <= 1'b0;
      ct_flag     <= 1'b0;
      cs_flag     <= 1'b0;
      ws_flag     <= 1'b0;
      fetch_count <= '0;
      write_count <= '0;
    end else begin
      fs_done_q <= FS_done;
      ct_done_q <= CT_done;
      cs_done_q <= CS_done;
      ws_done_q <= WS_done;

      // Pulses last exactly one cycle unless a transition below re-arms them.
      FS_start <= 1'b0;
      CT_start <= 1'b0;
      CS_start <= 1'b0;
      WS_start <= 1'b0;

      // Edges latch into the flags; a start issued below clears its flag (later assignment wins).
      if (fs_rise) fs_flag <= 1'b1;
      if (ct_rise) ct_flag <= 1'b1;
      if (cs_rise) cs_flag <= 1'b1;
      if (ws_rise) ws_flag <= 1'b1;

      case (state)
        S_IDLE: begin
          if (M2_start) begin
            state       <= S_LI_FS;
            M2_done     <= 1'b0;
            fetch_count <= '0;
            write_count <= '0;
            FS_start    <= 1'b1;
            fs_flag     <= 1'b0;
          end
        end

        // Lead-in: fetch block 0.
        S_LI_FS: begin
          if (fs_ok) begin
            state       <= S_LI_CT;
            fetch_count <= fetch_count + 12'd1;
            CT_start    <= 1'b1;
            ct_flag     <= 1'b0;
          end
        end

        // Lead-in: first transform of block 0.
        S_LI_CT: begin
          if (ct_ok) begin
            state    <= S_CC_A;
            CS_start <= 1'b1;
            FS_start <= 1'b1;
            cs_flag  <= 1'b0;
            fs_flag  <= 1'b0;
          end
        end

        // Steady state phase A: CS(k) alongside FS(k+1).
        S_CC_A: begin
          if (cs_ok && fs_ok) begin
            state       <= S_CC_B;
            fetch_count <= fetch_count + 12'd1;
            CT_start    <= 1'b1;
            WS_start    <= 1'b1;
            ct_flag     <= 1'b0;
            ws_flag     <= 1'b0;
          end
        end

        // Steady state phase B: CT(k+1) alongside WS(k); loop while blocks remain to fetch.
        S_CC_B: begin
          if (ct_ok && ws_ok) begin
            write_count <= write_count + 12'd1;
            CS_start    <= 1'b1;
            cs_flag     <= 1'b0;
            if (fetch_count < BLOCKS_TOTAL) begin
              state    <= S_CC_A;
              FS_start <= 1'b1;
              fs_flag  <= 1'b0;
            end else begin
              state <= S_LO_CS;
            end
          end
        end

        // Lead-out: second transform of the last block.
        S_LO_CS: begin
          if (cs_ok) begin
            state    <= S_LO_WS;
            WS_start <= 1'b1;
            ws_flag  <= 1'b0;
          end
        end

        // Lead-out: write back the last block.
        S_LO_WS: begin
          if (ws_ok) begin
            state       <= S_DONE;
            write_count <= write_count + 12'd1;
            M2_done     <= 1'b1;
          end
        end

        // One-cycle completion state; M2_done remains set in idle.
        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // SRAM port mux, decoded from the registered state; only WS may ever pull we_n low.
  always_comb begin
    SRAM_address    = '0;
    SRAM_write_data = '0;
    SRAM_we_n       = 1'b1;
    case (state)
      S_LI_FS, S_CC_A: begin
        SRAM_address = FS_SRAM_address;
      end
      S_CC_B, S_LO_WS: begin
        SRAM_address    = WS_SRAM_address;
        SRAM_write_data = WS_SRAM_write_data;
        SRAM_we_n       = WS_SRAM_we_n;
      end
      default: begin
        SRAM_address    = '0;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
      end
    endcase
  end

endmodule
